// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter over eight request lines.
// Registered grant index, valid flag and one-cycle done pulse.
module rr_grant_encoder #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       en,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       grant_done
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    ptr;
  logic [2:0]    ptr_nxt;
  logic [2:0]    idx_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          done_nxt;
  logic [2:0]    sel;
  logic [2:0]    cand;
  logic          hit;
  logic          release_now;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    sel  = ptr;
    hit  = 1'b0;
    cand = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        sel = cand;
        hit = 1'b1;
      end
    end
  end

  assign release_now = !req[grant_idx] || (cnt == HOLD_LIM);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = grant_idx;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && hit) begin
          state_nxt = GRANT;
          idx_nxt   = sel;
          cnt_nxt   = CNT_ONE;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          ptr_nxt   = grant_idx + 3'd1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 3'd0;
      cnt        <= '0;
      grant_idx  <= 3'd0;
      grant_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      grant_idx  <= idx_nxt;
      grant_done <= done_nxt;
    end
  end

  assign grant_valid = (state == GRANT);

endmodule
